// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the dual-port block RAM
package ram_pkg;

  typedef enum logic [1:0] {READ_FIRST, WRITE_FIRST, NO_CHANGE} write_mode_e;

  localparam int BYTE_W = 8;

  // Bits needed to hold value; never less than one so a 1-deep RAM still has an address port.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 0; v = v >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_out_pipe.sv
// rtl/ram_out_pipe.sv - response valid/err/data pipeline for one RAM port
module ram_out_pipe #(
  parameter int W       = 32,
  parameter int OUT_REG = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         oor,
  input  logic         keep,
  input  logic [W-1:0] raw,
  output logic [W-1:0] rdata,
  output logic         rvalid,
  output logic         err
);

  logic         v1, e1, k1;
  logic [W-1:0] s1_data;
  logic [W-1:0] held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      e1 <= 1'b0;
      k1 <= 1'b0;
    end else begin
      v1 <= req;
      e1 <= req & oor;
      k1 <= req & keep;
    end
  end

  // raw comes straight off the array register; errors and held writes override it.
  always_comb begin
    s1_data = raw;
    if (e1)      s1_data = '0;
    else if (k1) s1_data = held;
  end

  if (OUT_REG == 0) begin : g_lat1
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  held <= '0;
      else if (v1) held <= s1_data;
    end
    assign rdata  = v1 ? s1_data : held;
    assign rvalid = v1;
    assign err    = e1;
  end else begin : g_lat2
    logic         v2, e2;
    logic [W-1:0] d2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2 <= 1'b0;
        e2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) begin
          e2 <= e1;
          d2 <= s1_data;
        end
      end
    end
    assign held   = d2;
    assign rdata  = d2;
    assign rvalid = v2;
    assign err    = v2 & e2;
  end

endmodule

// File: rtl/dp_bram.sv
// rtl/dp_bram.sv - dual-port block RAM: port A read/write with byte enables, port B read-only
module dp_bram
  import ram_pkg::*;
#(
  parameter int    RAM_WIDTH  = 32,
  parameter int    RAM_DEPTH  = 1024,
  parameter int    OUT_REG    = 0,
  parameter string WRITE_MODE = "READ_FIRST",
  parameter string INIT_FILE  = "",
  localparam int   AW         = clogb2(RAM_DEPTH - 1),
  localparam int   NB         = RAM_WIDTH / BYTE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [NB-1:0]        a_be,
  input  logic [AW-1:0]        a_addr,
  input  logic [RAM_WIDTH-1:0] a_wdata,
  output logic [RAM_WIDTH-1:0] a_rdata,
  output logic                 a_rvalid,
  output logic                 a_err,
  input  logic                 b_req,
  input  logic [AW-1:0]        b_addr,
  output logic [RAM_WIDTH-1:0] b_rdata,
  output logic                 b_rvalid,
  output logic                 b_err
);

  localparam write_mode_e WM = (WRITE_MODE == "WRITE_FIRST") ? WRITE_FIRST :
                               (WRITE_MODE == "NO_CHANGE")   ? NO_CHANGE   : READ_FIRST;
  localparam logic [31:0] DEPTH_U = RAM_DEPTH;

  logic [RAM_WIDTH-1:0] mem [0:RAM_DEPTH-1];
  logic [RAM_WIDTH-1:0] a_q, b_q;
  logic                 a_in, b_in;

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
  end

  assign a_in = 32'(a_addr) < DEPTH_U;
  assign b_in = 32'(b_addr) < DEPTH_U;

  // Both ports share one process so synthesis sees a single true-dual-port array;
  // B's non-blocking read sees the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (a_req && a_in) begin
      if (!a_we || WM == READ_FIRST) begin
        a_q <= mem[a_addr];
      end else if (WM == WRITE_FIRST) begin
        for (int i = 0; i < NB; i++)
          a_q[i*BYTE_W +: BYTE_W] <= a_be[i] ? a_wdata[i*BYTE_W +: BYTE_W]
                                             : mem[a_addr][i*BYTE_W +: BYTE_W];
      end
      if (a_we) begin
        for (int i = 0; i < NB; i++)
          if (a_be[i]) mem[a_addr][i*BYTE_W +: BYTE_W] <= a_wdata[i*BYTE_W +: BYTE_W];
      end
    end
    if (b_req && b_in) b_q <= mem[b_addr];
  end

  ram_out_pipe #(.W(RAM_WIDTH), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (a_req),
    .oor    (!a_in),
    .keep   (a_we && WM == NO_CHANGE),
    .raw    (a_q),
    .rdata  (a_rdata),
    .rvalid (a_rvalid),
    .err    (a_err)
  );

  ram_out_pipe #(.W(RAM_WIDTH), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (b_req),
    .oor    (!b_in),
    .keep   (1'b0),
    .raw    (b_q),
    .rdata  (b_rdata),
    .rvalid (b_rvalid),
    .err    (b_err)
  );

  a_be_known: assert property (@(posedge clk) disable iff (!rst_n)
                               (a_req && a_we) |-> !$isunknown(a_be));

endmodule

// File: tb/tb_dp_bram.sv
// tb/tb_dp_bram.sv - self-checking bench for dp_bram across three write-mode/latency configurations
module tb_dp_bram;

  localparam int W  = 32;
  localparam int AW = 10;
  localparam int NB = 4;
  localparam int NI = 3;
  localparam int DEPTH_K [NI] = '{1000, 1024, 1000};
  localparam int LAT_K   [NI] = '{1, 2, 1};
  localparam int MODE_K  [NI] = '{0, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_req, a_we, b_req;
  logic [NB-1:0] a_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_wdata;
  logic [NI-1:0][W-1:0] a_rdata, b_rdata;
  logic [NI-1:0]        a_rvalid, a_err, b_rvalid, b_err;

  dp_bram #(.RAM_WIDTH(32), .RAM_DEPTH(1000), .OUT_REG(0), .WRITE_MODE("READ_FIRST"), .INIT_FILE("")) u_rf (
    .clk(clk), .rst_n(rst_n), .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]), .a_err(a_err[0]),
    .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]), .b_err(b_err[0]));

  dp_bram #(.RAM_WIDTH(32), .RAM_DEPTH(1024), .OUT_REG(1), .WRITE_MODE("WRITE_FIRST"), .INIT_FILE("")) u_wf (
    .clk(clk), .rst_n(rst_n), .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]), .a_err(a_err[1]),
    .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]), .b_err(b_err[1]));

  dp_bram #(.RAM_WIDTH(32), .RAM_DEPTH(1000), .OUT_REG(0), .WRITE_MODE("NO_CHANGE"), .INIT_FILE("")) u_nc (
    .clk(clk), .rst_n(rst_n), .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rdata(a_rdata[2]), .a_rvalid(a_rvalid[2]), .a_err(a_err[2]),
    .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata[2]), .b_rvalid(b_rvalid[2]), .b_err(b_err[2]));

  typedef struct {
    int         due;
    logic       err;
    logic [W-1:0] data;
  } resp_t;

  typedef struct {
    logic a_req; logic a_we; logic [3:0] a_be; logic [9:0] a_addr; logic [31:0] a_wdata;
    logic b_req; logic [9:0] b_addr;
    logic av; logic ae; logic [31:0] ad_rf; logic [31:0] ad_nc;
    logic bv; logic be; logic [31:0] bd;
  } vec_t;

  logic [W-1:0] mdl [NI][1024];
  resp_t        qa [NI][$];
  resp_t        qb [NI][$];
  logic [W-1:0] last_a [NI], last_b [NI], lastq_a [NI];
  int           ncyc;
  int           tests, fails;
  vec_t         tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %h, expected %h", name, ncyc, act, exp);
    end
  endtask

  task automatic flush_model();
    for (int k = 0; k < NI; k++) begin
      qa[k].delete();
      qb[k].delete();
      last_a[k]  = '0;
      last_b[k]  = '0;
      lastq_a[k] = '0;
    end
  endtask

  // Abstract view: every request yields one response LAT cycles later, computed at request time.
  task automatic model_edge();
    resp_t        r;
    logic [W-1:0] old_w, new_w, mask;
    ncyc++;
    if (!rst_n) begin
      flush_model();
      return;
    end
    for (int k = 0; k < NI; k++) begin
      if (b_req) begin
        r.due  = ncyc + LAT_K[k] - 1;
        r.err  = int'(b_addr) >= DEPTH_K[k];
        r.data = r.err ? '0 : mdl[k][b_addr];
        qb[k].push_back(r);
      end
      if (a_req) begin
        r.due = ncyc + LAT_K[k] - 1;
        r.err = int'(a_addr) >= DEPTH_K[k];
        if (r.err) begin
          r.data = '0;
        end else begin
          mask  = {{8{a_be[3]}}, {8{a_be[2]}}, {8{a_be[1]}}, {8{a_be[0]}}};
          old_w = mdl[k][a_addr];
          new_w = (old_w & ~mask) | (a_wdata & mask);
          if (!a_we)              r.data = old_w;
          else if (MODE_K[k] == 0) r.data = old_w;
          else if (MODE_K[k] == 1) r.data = new_w;
          else                     r.data = lastq_a[k];
          if (a_we) mdl[k][a_addr] = new_w;
        end
        lastq_a[k] = r.data;
        qa[k].push_back(r);
      end
    end
  endtask

  task automatic check_outputs();
    logic         ev, ee;
    logic [W-1:0] ed;
    for (int k = 0; k < NI; k++) begin
      ev = 1'b0; ee = 1'b0; ed = last_a[k];
      if (qa[k].size() > 0 && qa[k][0].due == ncyc) begin
        ev = 1'b1; ee = qa[k][0].err; ed = qa[k][0].data;
        last_a[k] = ed;
        void'(qa[k].pop_front());
      end
      chk($sformatf("inst%0d_port_a", k), {a_rvalid[k], a_err[k], a_rdata[k]}, {ev, ee, ed});
      ev = 1'b0; ee = 1'b0; ed = last_b[k];
      if (qb[k].size() > 0 && qb[k][0].due == ncyc) begin
        ev = 1'b1; ee = qb[k][0].err; ed = qb[k][0].data;
        last_b[k] = ed;
        void'(qb[k].pop_front());
      end
      chk($sformatf("inst%0d_port_b", k), {b_rvalid[k], b_err[k], b_rdata[k]}, {ev, ee, ed});
    end
  endtask

  task automatic step(input logic rst, input logic ar, input logic aw, input logic [3:0] abe,
                      input logic [9:0] aa, input logic [31:0] awd, input logic br, input logic [9:0] ba);
    rst_n = rst; a_req = ar; a_we = aw; a_be = abe; a_addr = aa; a_wdata = awd;
    b_req = br; b_addr = ba;
    if (!rst) begin
      #1;
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("inst%0d_reset_flags", k),
            {a_rvalid[k], a_err[k], b_rvalid[k], b_err[k], a_rdata[k]}, 64'd0);
        chk($sformatf("inst%0d_reset_bdata", k), {32'd0, b_rdata[k]}, 64'd0);
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [9:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return 10'($urandom_range(0, 15));
    return 10'($urandom_range(990, 1023));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    int  cnt;
    logic rr, ar;
    tests = 0; fails = 0; ncyc = 0;
    for (int k = 0; k < NI; k++) for (int j = 0; j < 1024; j++) mdl[k][j] = '0;
    flush_model();
    rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_addr = '0;

    tbl[0]  = '{1'b0,1'b0,4'h0,10'd0,32'h0,        1'b0,10'd0,    1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0};
    tbl[1]  = '{1'b1,1'b1,4'hF,10'd5,32'hAABBCCDD, 1'b0,10'd0,    1'b1,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0};
    tbl[2]  = '{1'b1,1'b1,4'h5,10'd5,32'h11223344, 1'b0,10'd0,    1'b1,1'b0,32'hAABBCCDD,32'h0, 1'b0,1'b0,32'h0};
    tbl[3]  = '{1'b0,1'b0,4'h0,10'd0,32'h0,        1'b1,10'd5,    1'b0,1'b0,32'hAABBCCDD,32'h0, 1'b1,1'b0,32'hAA22CC44};
    tbl[4]  = '{1'b1,1'b1,4'hF,10'd7,32'h1,        1'b0,10'd0,    1'b1,1'b0,32'h0,32'h0, 1'b0,1'b0,32'hAA22CC44};
    tbl[5]  = '{1'b1,1'b1,4'hF,10'd7,32'h2,        1'b0,10'd0,    1'b1,1'b0,32'h1,32'h0, 1'b0,1'b0,32'hAA22CC44};
    tbl[6]  = '{1'b1,1'b0,4'h0,10'd7,32'h0,        1'b0,10'd0,    1'b1,1'b0,32'h2,32'h2, 1'b0,1'b0,32'hAA22CC44};
    tbl[7]  = '{1'b1,1'b1,4'hF,10'd3,32'hDEAD,     1'b0,10'd0,    1'b1,1'b0,32'h0,32'h2, 1'b0,1'b0,32'hAA22CC44};
    tbl[8]  = '{1'b1,1'b1,4'hF,10'd3,32'hBEEF,     1'b1,10'd3,    1'b1,1'b0,32'hDEAD,32'h2, 1'b1,1'b0,32'hDEAD};
    tbl[9]  = '{1'b0,1'b0,4'h0,10'd0,32'h0,        1'b1,10'd3,    1'b0,1'b0,32'hDEAD,32'h2, 1'b1,1'b0,32'hBEEF};
    tbl[10] = '{1'b1,1'b1,4'hF,10'd1000,32'h5,     1'b0,10'd0,    1'b1,1'b1,32'h0,32'h0, 1'b0,1'b0,32'hBEEF};
    tbl[11] = '{1'b1,1'b0,4'h0,10'd1000,32'h0,     1'b1,10'd1023, 1'b1,1'b1,32'h0,32'h0, 1'b1,1'b1,32'h0};
    tbl[12] = '{1'b1,1'b0,4'h0,10'd999,32'h0,      1'b1,10'd5,    1'b1,1'b0,32'h0,32'h0, 1'b1,1'b0,32'hAA22CC44};
    tbl[13] = '{1'b1,1'b1,4'h0,10'd5,32'hFFFFFFFF, 1'b0,10'd0,    1'b1,1'b0,32'hAA22CC44,32'h0, 1'b0,1'b0,32'hAA22CC44};
    tbl[14] = '{1'b0,1'b0,4'h0,10'd0,32'h0,        1'b1,10'd5,    1'b0,1'b0,32'hAA22CC44,32'h0, 1'b1,1'b0,32'hAA22CC44};

    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);

    for (int i = 0; i < 15; i++) begin
      step(1'b1, tbl[i].a_req, tbl[i].a_we, tbl[i].a_be, tbl[i].a_addr, tbl[i].a_wdata,
           tbl[i].b_req, tbl[i].b_addr);
      chk($sformatf("tbl%0d_rf_a", i), {a_rvalid[0], a_err[0], a_rdata[0]},
          {tbl[i].av, tbl[i].ae, tbl[i].ad_rf});
      chk($sformatf("tbl%0d_nc_a", i), {a_rvalid[2], a_err[2], a_rdata[2]},
          {tbl[i].av, tbl[i].ae, tbl[i].ad_nc});
      chk($sformatf("tbl%0d_rf_b", i), {b_rvalid[0], b_err[0], b_rdata[0]},
          {tbl[i].bv, tbl[i].be, tbl[i].bd});
    end

    step(1'b1, 1'b1, 1'b1, 4'hF, 10'd7, 32'h3, 1'b0, 10'd0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
    chk("wf_write_first", {a_rvalid[1], a_rdata[1]}, {1'b1, 32'h3});

    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 4'hF, 10'(i), 32'h100 + 32'(i), 1'b0, 10'd0);
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0, (i < 16), 10'(i));
      cnt += int'(b_rvalid[1]);
    end
    chk("stream_count", 64'(cnt), 64'd16);

    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'(i));
      cnt += int'(b_rvalid[1]);
    end
    step(1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd7);
    chk("stream_before_reset", 64'(cnt), 64'd6);
    cnt = 0;
    for (int i = 8; i < 19; i++) begin
      step(1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0, (i < 16), 10'(i));
      cnt += int'(b_rvalid[1]);
    end
    chk("stream_after_reset", 64'(cnt), 64'd8);

    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 99) != 0);
      ar = rr && ($urandom_range(0, 1) != 0);
      step(rr, ar, 1'($urandom_range(0, 1)), 4'($urandom), rnd_addr(), $urandom,
           1'($urandom_range(0, 1)), rnd_addr());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
